// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//
// Round-robin arbiter and sequencer that shares one UART byte transmitter
// among N_REQ requesters. When the block is idle it grants the first
// requester at or after rr_ptr, latches that requester's byte, and runs the
// transmitter's start/done level handshake to completion. It then pulses
// req_ack for the winner and moves rr_ptr one past the winner, so a
// requester that keeps req high goes behind the others.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   req       level request per requester            [N_REQ]
//   req_data  byte per requester, i at [8i+7:8i]     [8*N_REQ]
//   req_ack   one-cycle completion pulse to winner   [N_REQ]
//   req_err   one-cycle abort pulse with req_ack (timeout build only)
//   busy      high from grant until ack
//   grant_id  index of the current or last granted requester [ID_W]
//   tx_start  level start to the transmitter
//   tx_data   latched byte to the transmitter; stable while busy
//   tx_done   transmitter done level, synchronous to clk
//
// Build option
//   UART_TX_ARB_TIMEOUT_EN  when defined, a transaction that has not
//   finished TIMEOUT cycles after the grant is aborted. The abort drops
//   tx_start and pulses req_ack and req_err together. Without the macro,
//   req_err is tied low and the arbiter waits on tx_done indefinitely.
// -----------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 200000,
    parameter int TO_W    = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ack,
    output logic               req_err,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_done
);

    // Reject illegal parameter combinations at elaboration time.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_arb: N_REQ must be in 2..8");
    end
    if ((1 << ID_W) < N_REQ) begin : g_bad_id_w
        $error("uart_tx_arb: ID_W too narrow for N_REQ");
    end
    if (TIMEOUT < 1 || (64'(1) << TO_W) <= 64'(TIMEOUT)) begin : g_bad_to_w
        $error("uart_tx_arb: need 1 <= TIMEOUT < 2**TO_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        RELEASE
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   next_ptr;

    // Round-robin select: rotate the request vector so that rr_ptr sits at
    // bit 0, take the lowest set bit, then add rr_ptr back modulo N_REQ.
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               sel_valid;
    logic [ID_W-1:0]    sel_off;
    logic [ID_W:0]      sel_sum;
    logic [ID_W-1:0]    sel_idx;

    assign req_dbl = {req, req};
    assign req_rot = N_REQ'(req_dbl >> rr_ptr);

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_off   = '0;
        // The loop runs downward, so the last hit it records is the lowest
        // offset from rr_ptr.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_valid = 1'b1;
                sel_off   = ID_W'(i);
            end
        end
        sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
        if (sel_sum >= (ID_W+1)'(N_REQ)) begin
            sel_sum = sel_sum - (ID_W+1)'(N_REQ);
        end
        sel_idx = sel_sum[ID_W-1:0];
    end

    assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // to_hit ends a transaction early. Outside the timeout build it is
    // constant low.
    logic to_hit;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT - 1));

    // The counter rests at zero in IDLE, so it reads zero on the first cycle
    // of START. It then counts through START and RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            req_err <= 1'b0;
        end else begin
            req_err <= to_hit;
            if (state == IDLE || to_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign to_hit  = 1'b0;
    assign req_err = 1'b0;
`endif

    // A transaction ends when tx_done is seen low in RELEASE, or when the
    // timeout fires.
    logic txn_end;
    assign txn_end = to_hit || (state == RELEASE && !tx_done);

    // NOTE: all state and registered outputs use non-blocking assignment, so
    // every right-hand side reads the value from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            req_ack  <= '0;
        end else begin
            req_ack <= '0;
            if (state != IDLE && txn_end) begin
                tx_start <= 1'b0;
                busy     <= 1'b0;
                req_ack  <= N_REQ'(1) << grant_id;
                rr_ptr   <= next_ptr;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_valid) begin
                            grant_id <= sel_idx;
                            tx_data  <= 8'(req_data >> {sel_idx, 3'b000});
                            tx_start <= 1'b1;
                            busy     <= 1'b1;
                            state    <= START;
                        end
                    end
                    START: begin
                        // A done level that was already high in IDLE counts
                        // only once it is sampled here, after the grant edge.
                        if (tx_done) begin
                            tx_start <= 1'b0;
                            state    <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        // Waiting for tx_done to drop. txn_end covers the exit.
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
